// File: rtl/output_driver_pkg.sv
// Shared types and default sizing for the output-driver frame scheduler.
package output_driver_pkg;
   localparam int N_CH_DEF      = 4;
   localparam int TICK_DIV_DEF  = 83333;
   localparam int DATA_LENG_DEF = 128;

   typedef enum logic [1:0] {IDLE, LOW, PULSE, DONE} od_state_e;
endpackage

// File: rtl/od_tick_gen.sv
// Clock-enable divider: one-cycle tick every TICK_DIV enabled cycles, no derived clock.
module od_tick_gen #(
   parameter int TICK_DIV = 4
) (
   input  logic clki,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clki or posedge rst) begin
      if (rst)      cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
   end

   assign tick = en && !clr && (cnt == LAST);
endmodule

// File: rtl/output_driver_scheduler.sv
// Round-robin arbiter sharing one pulse-frame engine (DATA_LENG low ticks + one high tick)
// across N_CH requesters; ticks come from a clock-enable divider.
module output_driver_scheduler
   import output_driver_pkg::*;
#(
   parameter int N_CH      = N_CH_DEF,
   parameter int TICK_DIV  = TICK_DIV_DEF,
   parameter int DATA_LENG = DATA_LENG_DEF
) (
   input  logic                    clki,
   input  logic                    rst,
   input  logic [N_CH-1:0]         start_req,
   input  logic                    abort,
   output logic [N_CH-1:0]         grant,
   output logic [$clog2(N_CH)-1:0] cur_ch,
   output logic [N_CH-1:0]         drv_out,
   output logic [N_CH-1:0]         done,
   output logic                    busy
);
   localparam int CHW = $clog2(N_CH);
   localparam int IW  = $clog2(DATA_LENG + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_LENG - 1);

   od_state_e       st, st_nxt;
   logic [N_CH-1:0] pend, pend_nxt, grant_nxt;
   logic [CHW-1:0]  cur_nxt, rr_last, rr_nxt;
   logic [IW-1:0]   idx, idx_nxt;
   logic            tick;

   // First pending channel strictly after 'last', wrapping back to 'last' itself.
   function automatic logic [CHW-1:0] rr_pick(input logic [N_CH-1:0] p, input logic [CHW-1:0] last);
      logic [CHW-1:0] c;
      rr_pick = last;
      for (int k = N_CH; k >= 1; k--) begin
         c = CHW'((int'(last) + k) % N_CH);
         if (p[c]) rr_pick = c;
      end
   endfunction

   od_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clki (clki),
      .rst  (rst),
      .en   (st != IDLE),
      .clr  (st == IDLE),
      .tick (tick)
   );

   always_ff @(posedge clki or posedge rst) begin
      if (rst) begin
         st      <= IDLE;
         pend    <= '0;
         grant   <= '0;
         cur_ch  <= '0;
         rr_last <= CHW'(N_CH - 1);
         idx     <= '0;
      end else begin
         st      <= st_nxt;
         pend    <= pend_nxt;
         grant   <= grant_nxt;
         cur_ch  <= cur_nxt;
         rr_last <= rr_nxt;
         idx     <= idx_nxt;
      end
   end

   always_comb begin
      st_nxt    = st;
      pend_nxt  = pend;
      grant_nxt = grant;
      cur_nxt   = cur_ch;
      rr_nxt    = rr_last;
      idx_nxt   = idx;
      case (st)
         IDLE: begin
            if (abort) pend_nxt = '0;
            else if (|pend) begin
               cur_nxt            = rr_pick(pend, rr_last);
               grant_nxt          = '0;
               grant_nxt[cur_nxt] = 1'b1;
               idx_nxt            = '0;
               st_nxt             = LOW;
            end
         end
         LOW, PULSE: begin
            if (abort) begin
               pend_nxt[cur_ch] = 1'b0;
               rr_nxt           = cur_ch;
               grant_nxt        = '0;
               st_nxt           = IDLE;
            end else if (tick) begin
               if (st == PULSE) st_nxt = DONE;
               else if (idx == LAST_IDX) begin
                  idx_nxt = '0;
                  st_nxt  = PULSE;
               end else idx_nxt = idx + IW'(1);
            end
         end
         DONE: begin
            pend_nxt[cur_ch] = 1'b0;
            if (abort) pend_nxt = '0;
            rr_nxt    = cur_ch;
            grant_nxt = '0;
            st_nxt    = IDLE;
         end
      endcase
      // A new request beats the clear above, but an abort in the same cycle drops it.
      if (!abort) pend_nxt = pend_nxt | start_req;
   end

   assign busy    = (st != IDLE);
   assign drv_out = (st == PULSE) ? grant : '0;
   assign done    = (st == DONE)  ? grant : '0;
endmodule

// File: tb/tb_output_driver_scheduler.sv
// Scoreboard bench: frame-time reference model pushes expected done events, monitor pops them.
module tb_output_driver_scheduler;
   localparam int N_CH = 4, TICK_DIV = 4, DATA_LENG = 3;
   localparam int LOWC  = DATA_LENG * TICK_DIV;
   localparam int FRAME = LOWC + TICK_DIV;

   logic            clki = 1'b0, rst = 1'b1, abort = 1'b0;
   logic [N_CH-1:0] start_req = '0;
   logic [N_CH-1:0] grant, drv_out, done;
   logic [1:0]      cur_ch;
   logic            busy;

   always #5 clki = ~clki;

   output_driver_scheduler #(.N_CH(N_CH), .TICK_DIV(TICK_DIV), .DATA_LENG(DATA_LENG)) dut (
      .clki(clki), .rst(rst), .start_req(start_req), .abort(abort),
      .grant(grant), .cur_ch(cur_ch), .drv_out(drv_out), .done(done), .busy(busy)
   );

   typedef struct {int ch; int cyc;} exp_t;
   exp_t q[$];
   int   served[$];
   int   checks = 0, passes = 0, cyc = 0;

   // reference model: frame position m_t counts cycles since grant (FRAME = done cycle)
   bit              m_act = 0;
   int              m_ch = 0, m_t = 0, m_rr = N_CH - 1;
   logic [N_CH-1:0] m_pend = '0;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [N_CH-1:0] oh(int c);
      logic [N_CH-1:0] r = '0;
      r[c] = 1'b1;
      return r;
   endfunction

   task automatic model_step();
      logic [N_CH-1:0] np = m_pend;
      cyc++;
      if (m_act) begin
         if (m_t == FRAME) begin
            np[m_ch] = 1'b0; m_rr = m_ch; m_act = 0;
            if (abort) np = '0;
         end else if (abort) begin
            np[m_ch] = 1'b0; m_rr = m_ch; m_act = 0;
         end else m_t++;
      end else if (abort) np = '0;
      else if (m_pend != 0) begin
         for (int k = N_CH; k >= 1; k--)
            if (m_pend[(m_rr + k) % N_CH]) m_ch = (m_rr + k) % N_CH;
         m_act = 1; m_t = 0;
      end
      if (!abort) np = np | start_req;
      m_pend = np;
      if (m_act && m_t == FRAME) q.push_back('{m_ch, cyc});
   endtask

   initial forever begin
      @(posedge clki or posedge rst);
      if (rst) begin
         m_act = 0; m_ch = 0; m_t = 0; m_rr = N_CH - 1; m_pend = '0;
         q.delete();
      end else model_step();
   end

   // monitor
   logic [N_CH-1:0] mon_eg, mon_ed;
   exp_t            mon_e;
   initial forever begin
      @(negedge clki);
      if (rst) begin
         chk("rst_grant", grant, 0); chk("rst_drv", drv_out, 0);
         chk("rst_done", done, 0);   chk("rst_busy", busy, 0); chk("rst_cur_ch", cur_ch, 0);
      end else begin
         mon_eg = m_act ? oh(m_ch) : '0;
         mon_ed = (m_act && m_t >= LOWC && m_t < FRAME) ? oh(m_ch) : '0;
         chk("grant", grant, mon_eg);
         chk("drv_out", drv_out, mon_ed);
         chk("busy", busy, m_act);
         if (m_act) chk("cur_ch", cur_ch, m_ch);
         chk("drv_outside_grant", drv_out & ~grant, 0);
         if (done != 0) begin
            if (q.size() == 0) chk("done_unexpected", done, 0);
            else begin
               mon_e = q.pop_front();
               chk("done_ch", done, oh(mon_e.ch));
               chk("done_cycle", cyc, mon_e.cyc);
               chk("done_busy", busy, 1);
            end
            for (int i = 0; i < N_CH; i++) if (done[i]) served.push_back(i);
         end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            chk("done_missing", done, oh(mon_e.ch));
         end
      end
   end

   task automatic step();
      @(posedge clki); #2;
   endtask

   task automatic idle(int n);
      repeat (n) step();
   endtask

   task automatic pulse_req(logic [N_CH-1:0] r, bit ab);
      start_req = r; abort = ab;
      step();
      start_req = '0; abort = 1'b0;
   endtask

   task automatic wait_grant(logic [N_CH-1:0] g, string name);
      bit ok = 0;
      for (int k = 0; k < 200; k++) begin
         if (grant == g) begin ok = 1; break; end
         step();
      end
      chk(name, ok, 1);
   endtask

   task automatic wait_done(string name);
      bit ok = 0;
      for (int k = 0; k < 200; k++) begin
         if (done != 0) begin ok = 1; break; end
         step();
      end
      chk(name, ok, 1);
   endtask

   initial begin
      int exp2[4] = '{0, 1, 3, 0};
      idle(2);
      rst = 1'b0;
      idle(2);

      // simultaneous requests served ch0, ch1, ch3; ch0 re-request lands after ch3
      served.delete();
      pulse_req(4'b1011, 0);
      wait_grant(4'b1000, "t2_wait_ch3");
      pulse_req(4'b0001, 0);
      idle(2 * FRAME + 8);
      chk("t2_served_n", served.size(), 4);
      for (int i = 0; i < 4 && i < served.size(); i++) chk("t2_order", served[i], exp2[i]);

      // single frame on ch2
      served.delete();
      pulse_req(4'b0100, 0);
      idle(FRAME + 6);
      chk("t1_served_n", served.size(), 1);
      if (served.size() > 0) chk("t1_ch", served[0], 2);

      // abort at the 5th LOW cycle with ch1 pending
      served.delete();
      pulse_req(4'b0001, 0);
      wait_grant(4'b0001, "t3_wait_ch0");
      pulse_req(4'b0010, 0);
      idle(3);
      pulse_req(4'b0000, 1);
      chk("t3_idle_after_abort", busy, 0);
      step();
      chk("t3_ch1_grant", grant, 4'b0010);
      idle(FRAME + 6);
      chk("t3_served_n", served.size(), 1);
      if (served.size() > 0) chk("t3_ch", served[0], 1);

      // async reset during PULSE
      pulse_req(4'b0100, 0);
      begin
         bit ok = 0;
         for (int k = 0; k < 200; k++) begin
            if (drv_out != 0) begin ok = 1; break; end
            step();
         end
         chk("t4_wait_pulse", ok, 1);
      end
      idle(1);
      rst = 1'b1;
      #1;
      chk("t4_rst_drv", drv_out, 0);
      chk("t4_rst_grant", grant, 0);
      chk("t4_rst_busy", busy, 0);
      idle(2);
      rst = 1'b0;
      idle(2);
      served.delete();
      pulse_req(4'b0100, 0);
      idle(FRAME + 6);
      chk("t4_served_n", served.size(), 1);

      // re-request of the finishing channel in its DONE cycle
      served.delete();
      pulse_req(4'b0010, 0);
      wait_done("t5_wait_done");
      pulse_req(4'b0010, 0);
      idle(FRAME + 8);
      chk("t5_served_n", served.size(), 2);
      if (served.size() > 1) chk("t5_reserve", served[1], 1);

      // abort and request together in IDLE
      served.delete();
      pulse_req(4'b0001, 1);
      idle(3);
      chk("t6_no_grant", grant, 0);
      chk("t6_not_busy", busy, 0);
      idle(FRAME);
      chk("t6_no_done", served.size(), 0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         start_req = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
         abort     = ($urandom_range(0, 59) == 0);
         step();
      end
      start_req = '0; abort = 1'b0;
      idle(5 * FRAME + 10);
      chk("drain_queue", q.size(), 0);
      chk("drain_busy", busy, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish, %0d/%0d", passes, checks);
      $fatal(1);
   end
endmodule
